// File: rtl/condition_handler_pkg.sv
// Shared definitions for the execute-side condition/status block:
// ARM condition codes, NZCV bit positions and the squash FSM encoding.
package condition_handler_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

endpackage

// File: rtl/condition_handler_cond_eval.sv
// Pure combinational evaluation of a 4-bit ARM condition field against NZCV.
module cond_eval
    import condition_handler_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/condition_handler.sv
// NZCV status register, EX-to-ID flag bypass, branch/link/NOP control and a
// one-cycle wrong-path squash after each taken branch, with a taken counter.
module condition_handler
    import condition_handler_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000,
    parameter int         CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [3:0]       ID_cond,
    input  logic             ID_B_instr,
    input  logic             ID_BL_instr,
    input  logic             EX_S,
    input  logic             ALU_N,
    input  logic             ALU_Z,
    input  logic             ALU_C,
    input  logic             ALU_V,
    output logic [3:0]       flags,
    output logic             C_in,
    output logic             cond_true,
    output logic             branch_taken,
    output logic             link_en,
    output logic             nop_sel,
    output logic             squash,
    output logic [CNT_W-1:0] taken_cnt
);

    state_t           state_reg;
    logic [3:0]       flags_reg;
    logic [CNT_W-1:0] taken_cnt_reg;
    logic [3:0]       alu_flags;
    logic [3:0]       eff_flags;
    logic             cond_pass;

    assign alu_flags = {ALU_N, ALU_Z, ALU_C, ALU_V};

    // A flag-setting instruction in EX is seen by the ID instruction right behind it.
    assign eff_flags = EX_S ? alu_flags : flags_reg;

    cond_eval u_cond_eval (
        .cond (ID_cond),
        .nzcv (eff_flags),
        .pass (cond_pass)
    );

    assign cond_true    = (state_reg == ST_RUN) && cond_pass;
    assign branch_taken = ID_B_instr && cond_true;
    assign link_en      = ID_BL_instr && cond_true;
    assign nop_sel      = !cond_true;
    assign squash       = (state_reg == ST_SQUASH);
    assign flags        = flags_reg;
    assign C_in         = flags_reg[FLAG_C];
    assign taken_cnt    = taken_cnt_reg;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_reg     <= ST_RUN;
            flags_reg     <= FLAGS_RST;
            taken_cnt_reg <= '0;
        end else begin
            if (EX_S) begin
                flags_reg <= alu_flags;
            end

            if (branch_taken && (taken_cnt_reg != {CNT_W{1'b1}})) begin
                taken_cnt_reg <= taken_cnt_reg + 1'b1;
            end

            case (state_reg)
                ST_RUN: begin
                    if (branch_taken) begin
                        state_reg <= ST_SQUASH;
                    end
                end
                ST_SQUASH: state_reg <= ST_RUN;
                default:   state_reg <= ST_RUN;
            endcase
        end
    end

endmodule
